grad_descent_ctrl: RTL and testbench
====================================

GRAD_DESCENT_CTRL -- requirements
Module: grad_descent_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 16'd256, meaning the iteration limit (1..65535).
REQ-002 The block SHALL have parameter TOL, default 32'h00000001, meaning the Q24.8 convergence threshold on |x_diff|.
REQ-003 The block SHALL have parameter TIMEOUT, default 16'd1024, meaning the maximum WAIT cycles per iteration before abort.
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset (polarity and synchronicity fixed), on the ports listed below.
REQ-005 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a descent run; sampled in IDLE only.
- x_init  in  32  signed Q24.8 starting point, captured with start.
- dp_start  out  1  one-cycle start pulse to the gradient datapath.
- dp_x  out  32  signed Q24.8 evaluation point to the datapath (= x_reg).
- dp_done  in  1  datapath result valid.
- dp_x_diff  in  32  signed Q24.8 step (learning_rate*gradient) from the datapath.
- dp_value  in  64  signed Q56.8 f(x) from the datapath.
- dp_overflow  in  1  datapath overflow flag.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle completion pulse.
- x_out  out  32  signed Q24.8 final/current x.
- value_out  out  64  last captured f(x).
- iter_count  out  16  number of completed iterations.
- status  out  2  00 converged, 01 max-iter, 10 overflow, 11 timeout.

Function
REQ-006 The FSM SHALL have the states IDLE, LAUNCH, WAIT, UPDATE and FIN, all transitions occurring on the clk rising edge.
REQ-007 In IDLE with start=1, the block SHALL load x_reg<=x_init, clear iter_count and status, and go to LAUNCH; busy SHALL rise in that same edge.
REQ-008 Start SHALL be ignored in every state other than IDLE; a run in progress SHALL NOT be restarted.
REQ-009 In LAUNCH, dp_start SHALL be 1 for exactly one cycle, the timeout counter SHALL be cleared, and the next state SHALL be WAIT.
REQ-010 dp_done SHALL be honoured only in WAIT; dp_done high in any other state SHALL be ignored.
REQ-011 In WAIT with dp_done=1, the block SHALL capture dp_x_diff, dp_value (to value_out) and dp_overflow, and go to UPDATE.
REQ-012 In WAIT with dp_done=0, the timeout counter SHALL increment; when it equals TIMEOUT-1 and dp_done=0, the block SHALL go to FIN with status=11 and leave x_reg unchanged.
REQ-013 In UPDATE, the block SHALL compute x_next = x_reg - x_diff in 33 bits and saturate it to 32'h7FFFFFFF / 32'h80000000; x_reg<=x_next; iter_count increments by 1.
REQ-014 The UPDATE termination priority SHALL be: captured overflow -> FIN, status 10; else |x_diff| <= TOL -> FIN, status 00; else iter_count+1 == MAX_ITER -> FIN, status 01; else -> LAUNCH.
REQ-015 |x_diff| SHALL be computed such that |32'h80000000| saturates to 32'h7FFFFFFF.
REQ-016 x_diff SHALL be applied in UPDATE even when the run terminates there; x_out SHALL always equal x_reg.
REQ-017 In FIN, done SHALL be 1 for one cycle and busy SHALL be 0; the next state SHALL be IDLE. Outputs SHALL hold until the next accepted start.
REQ-018 Iteration latency SHALL be 3 cycles plus the datapath latency (LAUNCH, WAIT..dp_done, UPDATE).

Reset
REQ-019 While rst=1, the block SHALL be in IDLE with dp_start=0, busy=0, done=0, x_out=0, value_out=0, iter_count=0, status=00, and the timeout counter=0, asynchronously and at any point mid-run.
REQ-020 After rst deasserts, the block SHALL require a new start; no pending run SHALL resume.

Verification
REQ-021 Convergence: x_init=0x00000A00, model dp_done 3 cycles after dp_start with dp_x_diff=0x00000100 twice then 0x00000001 -> done pulse, status=00, iter_count=3, x_out=0x000007FF.
REQ-022 Max-iter: MAX_ITER=4, dp_x_diff always 0x00000010 -> status=01, iter_count=4, x_out=x_init-0x40, exactly 4 dp_start pulses.
REQ-023 Overflow and saturation: x_init=0x80000010, dp_x_diff=0x00000100 -> x_out=0x80000000; separately, dp_overflow=1 on iteration 2 -> status=10, iter_count=2.
REQ-024 Timeout: TIMEOUT=8, dp_done never asserted -> done exactly 8 cycles after the WAIT entry, status=11, x_out=x_init.
REQ-025 Handshake robustness: dp_done held high through LAUNCH, and start pulsed while busy -> the extra dp_done is ignored, no second run starts, and one done pulse is produced per accepted start.
REQ-026 Mid-run reset: assert rst during WAIT of iteration 2 -> all outputs are 0 immediately; after release, no dp_start until a new start.

Source files
------------

// File: rtl/grad_descent_ctrl_if.sv
// Signal bundle between the descent controller and its environment (host + gradient datapath).
// master drives the run request and datapath results; slave is the controller.
interface grad_descent_ctrl_if;
    logic        start;
    logic [31:0] x_init;
    logic        dp_start;
    logic [31:0] dp_x;
    logic        dp_done;
    logic [31:0] dp_x_diff;
    logic [63:0] dp_value;
    logic        dp_overflow;
    logic        busy;
    logic        done;
    logic [31:0] x_out;
    logic [63:0] value_out;
    logic [15:0] iter_count;
    logic [1:0]  status;

    modport master (
        output start, x_init, dp_done, dp_x_diff, dp_value, dp_overflow,
        input  dp_start, dp_x, busy, done, x_out, value_out, iter_count, status
    );

    modport slave (
        input  start, x_init, dp_done, dp_x_diff, dp_value, dp_overflow,
        output dp_start, dp_x, busy, done, x_out, value_out, iter_count, status
    );
endinterface

// File: rtl/grad_descent_ctrl.sv
// Iterates x <- sat(x - dp_x_diff) via an external gradient datapath until converged, max-iter, overflow or timeout.
// Per iteration: LAUNCH + WAIT (until dp_done) + UPDATE; the datapath is never stalled, a silent one is aborted after TIMEOUT cycles.
module grad_descent_ctrl #(
    parameter logic [15:0] MAX_ITER = 16'd256,
    parameter logic [31:0] TOL      = 32'h00000001,
    parameter logic [15:0] TIMEOUT  = 16'd1024
) (
    input  logic                     clk,
    input  logic                     rst,
    grad_descent_ctrl_if.slave       bus
);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, UPDATE, FIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] x_reg;
    logic [31:0] x_diff;
    logic        ovf;
    logic [63:0] value_q;
    logic [15:0] iter_q;
    logic [1:0]  status_q;
    logic [15:0] tcnt;

    logic [32:0] x_sub;
    logic [31:0] x_next;
    logic [31:0] diff_abs;
    logic [15:0] iter_inc;
    logic [1:0]  fin_status;

    assign x_sub    = {x_reg[31], x_reg} - {x_diff[31], x_diff};
    assign iter_inc = iter_q + 16'd1;

    always_comb begin
        x_next = x_sub[31:0];
        if (x_sub[32] != x_sub[31]) begin
            x_next = x_sub[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // The most negative step has no positive twin; clamp its magnitude.
    always_comb begin
        diff_abs = x_diff;
        if (x_diff[31]) begin
            diff_abs = (x_diff == 32'h8000_0000) ? 32'h7FFF_FFFF : (~x_diff + 32'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        fin_status = status_q;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.dp_done) begin
                    state_nxt = UPDATE;
                end else if (tcnt == TIMEOUT - 16'd1) begin
                    state_nxt  = FIN;
                    fin_status = 2'b11;
                end
            end
            UPDATE: begin
                state_nxt = FIN;
                if (ovf) begin
                    fin_status = 2'b10;
                end else if (diff_abs <= TOL) begin
                    fin_status = 2'b00;
                end else if (iter_inc == MAX_ITER) begin
                    fin_status = 2'b01;
                end else begin
                    state_nxt = LAUNCH;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg    <= '0;
            x_diff   <= '0;
            ovf      <= 1'b0;
            value_q  <= '0;
            iter_q   <= '0;
            status_q <= 2'b00;
            tcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_reg    <= bus.x_init;
                        iter_q   <= '0;
                        status_q <= 2'b00;
                    end
                end
                LAUNCH: begin
                    tcnt <= '0;
                end
                WAIT: begin
                    if (bus.dp_done) begin
                        x_diff  <= bus.dp_x_diff;
                        value_q <= bus.dp_value;
                        ovf     <= bus.dp_overflow;
                    end else begin
                        tcnt     <= tcnt + 16'd1;
                        status_q <= fin_status;
                    end
                end
                UPDATE: begin
                    // The step is applied even on the terminating iteration.
                    x_reg    <= x_next;
                    iter_q   <= iter_inc;
                    status_q <= fin_status;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dp_start   = (state == LAUNCH);
    assign bus.dp_x       = x_reg;
    assign bus.busy       = (state == LAUNCH) || (state == WAIT) || (state == UPDATE);
    assign bus.done       = (state == FIN);
    assign bus.x_out      = x_reg;
    assign bus.value_out  = value_q;
    assign bus.iter_count = iter_q;
    assign bus.status     = status_q;

endmodule

// File: tb/tb_grad_descent_ctrl.sv
// Self-checking bench: a responder plays the gradient datapath, a plain-arithmetic model predicts each run.
module tb_grad_descent_ctrl;

    localparam int          MAX_ITER_P = 4;
    localparam logic [31:0] TOL_P      = 32'h0000_0001;
    localparam int          TIMEOUT_P  = 8;
    localparam longint      XMAX       = 64'sd2147483647;
    localparam longint      XMIN       = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    grad_descent_ctrl_if ifc ();

    grad_descent_ctrl #(
        .MAX_ITER (16'(MAX_ITER_P)),
        .TOL      (TOL_P),
        .TIMEOUT  (16'(TIMEOUT_P))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // responder configuration, written only by the test tasks
    logic [31:0] dq [0:7];
    int          lat = 3;
    int          ovf_iter = -1;
    bit          rsp_on = 1'b1;
    bit          hold_mode = 1'b0;
    int          base = 0;

    // responder state
    int          n_launch = 0;
    int          rsp_cnt = 0;
    logic [31:0] lx = '0;
    bit          hold_pend = 1'b0;
    bit          hold_drop = 1'b0;
    int          n_done = 0;

    always @(negedge clk) begin
        int idx;
        if (!hold_mode) begin
            hold_pend = 1'b0;
            hold_drop = 1'b0;
        end else if (hold_pend) begin
            hold_drop = 1'b1;
        end
        ifc.dp_done     = 1'b0;
        ifc.dp_overflow = 1'b0;
        ifc.dp_x_diff   = 32'h0;
        ifc.dp_value    = 64'h0;
        if (hold_mode && !hold_drop) begin
            // bogus result that would visibly corrupt the run if honoured
            ifc.dp_done     = 1'b1;
            ifc.dp_x_diff   = 32'h4000_0000;
            ifc.dp_overflow = 1'b1;
            ifc.dp_value    = '1;
        end
        if (rst) begin
            rsp_cnt = 0;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                idx             = n_launch - 1 - base;
                ifc.dp_done     = 1'b1;
                ifc.dp_x_diff   = dq[idx & 7];
                ifc.dp_overflow = (idx == ovf_iter);
                ifc.dp_value    = {~lx, lx};
            end
        end
        if (ifc.dp_start === 1'b1 && !rst) begin
            n_launch++;
            lx = ifc.dp_x;
            if (rsp_on) rsp_cnt = lat;
            if (hold_mode) hold_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (ifc.done === 1'b1) n_done++;
    end

    // Reference: walk the step list with clamped integer arithmetic.
    function automatic void model_run(input logic [31:0] xi, input int ovf_i,
                                      output logic [31:0] xe, output logic [15:0] ie,
                                      output logic [1:0] se, output logic [63:0] ve, output int ne);
        longint x, d, a;
        x = longint'($signed(xi));
        xe = xi; ie = '0; se = '0; ve = '0; ne = 0;
        for (int i = 0; i < 8; i++) begin
            ve = {~x[31:0], x[31:0]};
            d  = longint'($signed(dq[i]));
            x  = x - d;
            if (x > XMAX) x = XMAX;
            if (x < XMIN) x = XMIN;
            a = (d < 0) ? -d : d;
            if (a > XMAX) a = XMAX;
            ne = i + 1;
            ie = 16'(i + 1);
            xe = x[31:0];
            if (i == ovf_i) begin se = 2'b10; break; end
            if (a <= longint'(TOL_P)) begin se = 2'b00; break; end
            if (i + 1 == MAX_ITER_P) begin se = 2'b01; break; end
        end
    endfunction

    task automatic do_run(input string tag, input logic [31:0] xi, input int lat_i,
                          input int ovf_i, input bit pulses, input bit hold);
        logic [31:0] xe;
        logic [15:0] ie;
        logic [1:0]  se;
        logic [63:0] ve;
        int ne, c0, nd0, nl0;
        bit seen;
        model_run(xi, ovf_i, xe, ie, se, ve, ne);
        @(negedge clk);
        lat = lat_i; ovf_iter = ovf_i; rsp_on = 1'b1; hold_mode = hold; base = n_launch;
        nl0 = n_launch; nd0 = n_done; c0 = cyc;
        ifc.start = 1'b1; ifc.x_init = xi;
        @(negedge clk);
        ifc.start = 1'b0; ifc.x_init = $urandom;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (ifc.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                ifc.start = pulses && (ifc.busy === 1'b1) && ($urandom_range(0, 2) == 0);
                if (ifc.start) ifc.x_init = $urandom;
                @(negedge clk);
            end
        end
        ifc.start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: no done within 200 cycles", tag);
            hold_mode = 1'b0;
            return;
        end
        checks++;
        if (cyc - c0 !== 1 + ne * (lat_i + 2)) begin
            errors++; $display("FAIL %s latency got %0d want %0d", tag, cyc - c0, 1 + ne * (lat_i + 2));
        end
        checks++;
        if (ifc.busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_fin got %b want 0", tag, ifc.busy); end
        checks++;
        if (ifc.x_out !== xe) begin errors++; $display("FAIL %s x_out got %h want %h", tag, ifc.x_out, xe); end
        checks++;
        if (ifc.iter_count !== ie) begin errors++; $display("FAIL %s iter_count got %0d want %0d", tag, ifc.iter_count, ie); end
        checks++;
        if (ifc.status !== se) begin errors++; $display("FAIL %s status got %b want %b", tag, ifc.status, se); end
        checks++;
        if (ifc.value_out !== ve) begin errors++; $display("FAIL %s value_out got %h want %h", tag, ifc.value_out, ve); end
        @(negedge clk);
        hold_mode = 1'b0;
        checks++;
        if (ifc.done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", tag, ifc.done); end
        repeat (4) @(negedge clk);
        checks++;
        if (n_done - nd0 !== 1) begin errors++; $display("FAIL %s done_count got %0d want 1", tag, n_done - nd0); end
        checks++;
        if (n_launch - nl0 !== ne) begin errors++; $display("FAIL %s dp_start_count got %0d want %0d", tag, n_launch - nl0, ne); end
        checks++;
        if (ifc.x_out !== xe || ifc.status !== se) begin
            errors++; $display("FAIL %s hold_after_done got %h/%b want %h/%b", tag, ifc.x_out, ifc.status, xe, se);
        end
    endtask

    task automatic fill_dq(input logic [31:0] v);
        for (int i = 0; i < 8; i++) dq[i] = v;
    endtask

    task automatic test_reset();
        logic [117:0] outs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        ifc.start = 1'b1; ifc.x_init = 32'h1234_5678;
        @(negedge clk);
        outs = {ifc.busy, ifc.done, ifc.dp_start, ifc.x_out, ifc.value_out, ifc.iter_count, ifc.status};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        ifc.start = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (n_launch !== 0 || ifc.busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_resume got launches=%0d busy=%b want 0/0", n_launch, ifc.busy);
        end
    endtask

    task automatic test_converge();
        fill_dq(32'h0000_0100);
        dq[2] = 32'h0000_0001;
        do_run("converge", 32'h0000_0A00, 3, -1, 1'b0, 1'b0);
        checks++;
        if (ifc.x_out !== 32'h0000_07FF || ifc.iter_count !== 16'd3 || ifc.status !== 2'b00) begin
            errors++; $display("FAIL converge_const got %h/%0d/%b want 000007ff/3/00", ifc.x_out, ifc.iter_count, ifc.status);
        end
    endtask

    task automatic test_max_iter();
        fill_dq(32'h0000_0010);
        do_run("max_iter", 32'h1234_5600, 3, -1, 1'b0, 1'b0);
        checks++;
        if (ifc.x_out !== 32'h1234_55C0 || ifc.iter_count !== 16'd4 || ifc.status !== 2'b01) begin
            errors++; $display("FAIL max_iter_const got %h/%0d/%b want 123455c0/4/01", ifc.x_out, ifc.iter_count, ifc.status);
        end
    endtask

    task automatic test_saturation();
        fill_dq(32'h0000_0100);
        do_run("sat_neg", 32'h8000_0010, 2, -1, 1'b0, 1'b0);
        checks++;
        if (ifc.x_out !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg_const got %h want 80000000", ifc.x_out); end
        fill_dq(32'hFFFF_F000);
        do_run("sat_pos", 32'h7FFF_F800, 1, -1, 1'b0, 1'b0);
        fill_dq(32'h8000_0000);
        do_run("min_step", 32'h0000_0000, 2, -1, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        fill_dq(32'h0000_0020);
        do_run("overflow", 32'h0001_0000, 3, 1, 1'b0, 1'b0);
        checks++;
        if (ifc.status !== 2'b10 || ifc.iter_count !== 16'd2) begin
            errors++; $display("FAIL overflow_const got %b/%0d want 10/2", ifc.status, ifc.iter_count);
        end
        fill_dq(32'h0000_0001);
        do_run("ovf_over_tol", 32'h0000_0400, 2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int  l0;
        bit  got;
        logic [31:0] xi;
        xi = 32'h0000_5A00;
        @(negedge clk);
        rsp_on = 1'b0;
        ifc.start = 1'b1; ifc.x_init = xi;
        @(negedge clk);
        ifc.start = 1'b0;
        l0 = cyc;
        checks++;
        if (ifc.dp_start !== 1'b1) begin errors++; $display("FAIL timeout_launch dp_start got %b want 1", ifc.dp_start); end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL timeout_done: no done within 40 cycles");
        end else begin
            checks++;
            if (cyc - l0 !== TIMEOUT_P + 1) begin
                errors++; $display("FAIL timeout_latency got %0d want %0d", cyc - l0 - 1, TIMEOUT_P);
            end
            checks++;
            if (ifc.status !== 2'b11 || ifc.x_out !== xi || ifc.iter_count !== 16'd0) begin
                errors++; $display("FAIL timeout_result got %b/%h/%0d want 11/%h/0", ifc.status, ifc.x_out, ifc.iter_count, xi);
            end
        end
        @(negedge clk);
        rsp_on = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_handshake();
        fill_dq(32'h0000_0100);
        dq[2] = 32'hFFFF_FFFF;
        do_run("handshake", 32'h0000_3000, 3, -1, 1'b1, 1'b1);
        fill_dq(32'h0000_0040);
        do_run("busy_start", 32'hFFF0_0000, 1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_midrun_reset();
        int  seen_starts;
        bit  stray;
        fill_dq(32'h0000_0010);
        @(negedge clk);
        lat = 3; ovf_iter = -1; rsp_on = 1'b1; base = n_launch;
        ifc.start = 1'b1; ifc.x_init = 32'h0000_8000;
        @(negedge clk);
        ifc.start = 1'b0;
        seen_starts = 0;
        for (int k = 0; k < 60 && seen_starts < 2; k++) begin
            if (ifc.dp_start === 1'b1) seen_starts++;
            if (seen_starts < 2) @(negedge clk);
        end
        checks++;
        if (seen_starts != 2) begin
            errors++; $display("FAIL midrun_second_launch got %0d launches want 2", seen_starts);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ifc.busy, ifc.done, ifc.dp_start, ifc.x_out, ifc.value_out, ifc.iter_count, ifc.status} !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs got busy=%b x=%h val=%h it=%0d st=%b want all 0",
                               ifc.busy, ifc.x_out, ifc.value_out, ifc.iter_count, ifc.status);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ifc.dp_start !== 1'b0 || ifc.busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL midrun_no_resume got activity after reset want none"); end
    endtask

    task automatic test_random();
        int kind, ovf_i;
        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < 8; i++) begin
                kind = $urandom_range(0, 5);
                case (kind)
                    0:       dq[i] = 32'($urandom_range(0, 2)) - 32'd1;
                    1, 2:    dq[i] = $urandom;
                    3:       dq[i] = 32'h8000_0000;
                    default: dq[i] = 32'($urandom_range(0, 32'h1_FFFF)) - 32'h1_0000;
                endcase
            end
            ovf_i = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
            do_run("random", $urandom, $urandom_range(1, TIMEOUT_P - 1), ovf_i, 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.start = 1'b0;
        ifc.x_init = '0;
        fill_dq(32'h0);
        test_reset();
        test_converge();
        test_max_iter();
        test_saturation();
        test_overflow();
        test_timeout();
        test_handshake();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
